// File: rtl/sdcard_pkg.sv
// Shared definitions for the SD-card APB master and its companion APB interface.
package sdcard_pkg;

  localparam int DEFAULT_ADDR_WIDTH     = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } sdcard_apb_state_e;

endpackage

// File: rtl/sdcard_apb_master.sv
// Single-outstanding APB master: one command in, one SETUP/ACCESS transfer out,
// one response back, with a bounded wait on PREADY.
module sdcard_apb_master
  import sdcard_pkg::*;
#(
  parameter int SDCARD_APB_ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES        = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                             PCLK_i,
  input  logic                             PRESETn_i,
  // Command and response channels both use valid/ready: a beat transfers on
  // the rising edge where valid and ready are both high; the source holds
  // its payload stable while valid is high and ready is low.
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic                             cmd_write_i,
  input  logic [SDCARD_APB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]                      cmd_wdata_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [31:0]                      rsp_rdata_o,
  output logic                             rsp_error_o,
  output logic                             rsp_timeout_o,
  output logic                             PSEL_o,
  output logic                             PENABLE_o,
  output logic                             PWRITE_o,
  output logic [SDCARD_APB_ADDR_WIDTH-1:0] PADDR_o,
  output logic [31:0]                      PWDATA_o,
  input  logic [31:0]                      PRDATA_i,
  input  logic                             PREADY_i,
  input  logic                             PSLVERR_i,
  output sdcard_apb_state_e                dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  sdcard_apb_state_e state;
  logic [CW-1:0]     wait_cnt;

  assign cmd_ready_o = (state == IDLE);
  assign dbg_state   = state;

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      PSEL_o        <= 1'b0;
      PENABLE_o     <= 1'b0;
      PWRITE_o      <= 1'b0;
      PADDR_o       <= '0;
      PWDATA_o      <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_error_o   <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            PWRITE_o  <= cmd_write_i;
            PADDR_o   <= cmd_addr_i;
            PWDATA_o  <= cmd_write_i ? cmd_wdata_i : 32'd0;
            PSEL_o    <= 1'b1;
            PENABLE_o <= 1'b0;
            wait_cnt  <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          PENABLE_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (PREADY_i) begin
            rsp_error_o   <= PSLVERR_i;
            rsp_timeout_o <= 1'b0;
            rsp_rdata_o   <= (!PWRITE_o && !PSLVERR_i) ? PRDATA_i : 32'd0;
            rsp_valid_o   <= 1'b1;
            PSEL_o        <= 1'b0;
            PENABLE_o     <= 1'b0;
            state         <= RESP;
          end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            // Slave never answered within the allowed window: abandon it.
            rsp_error_o   <= 1'b1;
            rsp_timeout_o <= 1'b1;
            rsp_rdata_o   <= 32'd0;
            rsp_valid_o   <= 1'b1;
            PSEL_o        <= 1'b0;
            PENABLE_o     <= 1'b0;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdcard_apb_master.sv
// Randomized bench for sdcard_apb_master with an in-bench APB slave and a
// transaction-level response model.
module tb_sdcard_apb_master;
  import sdcard_pkg::*;

  localparam int AW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_error, rsp_timeout;
  logic [31:0]   rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata, prdata = '0;
  logic          pready = 1'b0, pslverr = 1'b0;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  logic [33:0] exp_q[$];

  sdcard_apb_master #(.SDCARD_APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK_i(clk), .PRESETn_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error), .rsp_timeout_o(rsp_timeout),
    .PSEL_o(psel), .PENABLE_o(penable), .PWRITE_o(pwrite), .PADDR_o(paddr),
    .PWDATA_o(pwdata), .PRDATA_i(prdata), .PREADY_i(pready), .PSLVERR_i(pslverr),
    .dbg_state(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Response as {error, timeout, rdata}: a slave that stays silent for TO
  // cycles causes a timeout, otherwise the slave's error and data decide.
  function automatic logic [33:0] model(input logic wr, input int waits,
                                        input logic err, input logic [31:0] rd);
    if (waits >= TO) return {1'b1, 1'b1, 32'd0};
    return {err, 1'b0, (wr || err) ? 32'd0 : rd};
  endfunction

  task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input int waits, input logic err, input logic [31:0] rd,
                        input int hold);
    int acc;
    logic [33:0] e;
    logic [31:0] exp_wd;
    exp_q.push_back(model(wr, waits, err, rd));
    exp_wd = wr ? wd : 32'd0;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    @(negedge clk);
    // cmd_valid stays high with scrambled payload; it must be ignored.
    cmd_write = ~wr; cmd_addr = AW'($urandom); cmd_wdata = $urandom;
    check("setup_psel", psel, 1);
    check("setup_penable", penable, 0);
    check("setup_paddr", paddr, addr);
    check("setup_pwrite", pwrite, wr);
    check("setup_pwdata", pwdata, exp_wd);
    check("setup_cmd_ready", cmd_ready, 0);
    acc = 0;
    for (int k = 0; k < TO + 2; k++) begin
      @(negedge clk);
      if (!(psel && penable)) break;
      acc++;
      check("access_paddr", paddr, addr);
      check("access_pwrite", pwrite, wr);
      check("access_pwdata", pwdata, exp_wd);
      check("access_rsp_valid", rsp_valid, 0);
      pready  = (k == waits);
      pslverr = (k == waits) ? err : 1'($urandom);
      prdata  = (k == waits) ? rd : $urandom;
    end
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    check("access_cycles", acc, (waits + 1 < TO) ? waits + 1 : TO);
    e = exp_q.pop_front();
    check("rsp_valid", rsp_valid, 1);
    check("rsp_psel_low", psel, 0);
    check("rsp_payload", {rsp_error, rsp_timeout, rsp_rdata}, e);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_payload", {rsp_error, rsp_timeout, rsp_rdata}, e);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_psel", psel, 0);
    end
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("done_rsp_valid", rsp_valid, 0);
    check("done_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_apb", {psel, penable, pwrite, paddr, pwdata}, 0);
    check("rst_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_txn(1'b1, 16'h0010, 32'hDEADBEEF, 0, 1'b0, 32'h0, 0);
    do_txn(1'b0, 16'h0004, 32'hAAAA5555, 3, 1'b0, 32'h12345678, 0);
    do_txn(1'b0, 16'h0008, 32'h0, 0, 1'b1, 32'hCAFEF00D, 0);
    do_txn(1'b0, 16'h000C, 32'h0, 10, 1'b0, 32'h11111111, 0);
    do_txn(1'b1, 16'h0020, 32'h01020304, 3, 1'b0, 32'h0, 0);
    do_txn(1'b0, 16'h0030, 32'h0, 1, 1'b0, 32'h87654321, 5);

    // Reset in the middle of ACCESS: transfer dropped, no response.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0040;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_access", {psel, penable}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("rst_mid_psel", psel, 0);
    check("rst_mid_penable", penable, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    pready = 1'b1; prdata = 32'h5A5A5A5A;
    @(negedge clk);
    pready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 0);
      check("post_rst_no_psel", psel, 0);
    end
    do_txn(1'b0, 16'h0044, 32'h0, 0, 1'b0, 32'h0BADF00D, 0);

    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom), AW'($urandom), $urandom, $urandom_range(0, TO + 1),
             ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/sdcard_apb_master.md
SDCARD_APB_MASTER -- requirements
Module: sdcard_apb_master

Interface
REQ-001 SHALL have parameter SDCARD_APB_ADDR_WIDTH, default 16: APB address width (AW).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256: max ACCESS cycles awaiting PREADY_i; legal range >=1.
REQ-003 SHALL have port PCLK_i  input  1  single clock; all flops on rising edge.
REQ-004 SHALL have port PRESETn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid_i  input  1  command request.
REQ-006 SHALL have port cmd_ready_o  output  1  command accept.
REQ-007 SHALL have port cmd_write_i  input  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr_i  input  AW  target address.
REQ-009 SHALL have port cmd_wdata_i  input  32  write data.
REQ-010 SHALL have port rsp_valid_o  output  1  response available.
REQ-011 SHALL have port rsp_ready_i  input  1  response consumed.
REQ-012 SHALL have port rsp_rdata_o  output  32  read data (0 for writes and errors).
REQ-013 SHALL have port rsp_error_o  output  1  PSLVERR or timeout.
REQ-014 SHALL have port rsp_timeout_o  output  1  error caused by timeout.
REQ-015 SHALL have APB outputs PSEL_o 1, PENABLE_o 1, PWRITE_o 1, PADDR_o AW, PWDATA_o 32.
REQ-016 SHALL have APB inputs PRDATA_i 32, PREADY_i 1, PSLVERR_i 1.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; only these transitions: IDLE->SETUP, SETUP->ACCESS, ACCESS->RESP, RESP->IDLE.
REQ-018 SHALL drive cmd_ready_o = (state==IDLE), combinationally; on cmd_valid_i&&cmd_ready_o it SHALL register write/addr/wdata into PWRITE_o/PADDR_o/PWDATA_o and go to SETUP.
REQ-019 SHALL force PWDATA_o=0 on read commands.
REQ-020 SHALL ignore cmd_* inputs outside IDLE.
REQ-021 SETUP: SHALL drive PSEL_o=1, PENABLE_o=0 for exactly one cycle, then go to ACCESS.
REQ-022 ACCESS: SHALL drive PSEL_o=1, PENABLE_o=1; PADDR_o/PWRITE_o/PWDATA_o SHALL stay stable from SETUP until ACCESS exits.
REQ-023 ACCESS with PREADY_i=1: SHALL register rsp_error_o=PSLVERR_i, rsp_timeout_o=0, rsp_rdata_o=PRDATA_i if read and !PSLVERR_i else 0, then go to RESP.
REQ-024 SHALL sample PSLVERR_i and PRDATA_i only in ACCESS cycles where PREADY_i=1.
REQ-025 SHALL clear the wait counter on SETUP entry and increment it each ACCESS cycle with PREADY_i=0; width $clog2(TIMEOUT_CYCLES+1).
REQ-026 ACCESS with PREADY_i=0 and counter==TIMEOUT_CYCLES-1: SHALL set rsp_error_o=1, rsp_timeout_o=1, rsp_rdata_o=0 and go to RESP; ACCESS SHALL last at most TIMEOUT_CYCLES cycles.
REQ-027 PREADY_i=1 on the final allowed cycle SHALL complete normally (no timeout).
REQ-028 PSEL_o and PENABLE_o SHALL be 0 in IDLE and RESP, so there is no back-to-back APB transfer.
REQ-029 RESP: SHALL hold rsp_valid_o=1 with stable payload until rsp_ready_i=1, then go to IDLE.
REQ-030 Latency: command handshake at cycle N SHALL give PSEL_o at N+1, PENABLE_o at N+2, rsp_valid_o one cycle after PREADY_i sampled high; minimum 4 cycles per command.

Reset
REQ-031 PRESETn_i low SHALL immediately force state=IDLE, counter=0, PSEL_o/PENABLE_o/PWRITE_o/rsp_valid_o/rsp_error_o/rsp_timeout_o=0, PADDR_o/PWDATA_o/rsp_rdata_o=0; cmd_ready_o=1 (IDLE).
REQ-032 Reset mid-transaction SHALL drop the transfer with no response generated.

Structure
REQ-033 SHALL place the APB FSM state typedef and the default SDCARD_APB_ADDR_WIDTH/TIMEOUT_CYCLES constants in shared package sdcard_pkg, reusable by sdcard_apb_interface.
REQ-034 SHALL be a single module with no sub-modules.

Verification
REQ-035 Write 0x0010<-0xDEADBEEF, PREADY_i=1 immediately -> PSEL_o at N+1, PENABLE_o at N+2, rsp_valid_o=1 at N+3, rsp_error_o=0.
REQ-036 Read 0x0004, PREADY_i after 3 wait cycles, PRDATA_i=0x12345678 -> rsp_rdata_o=0x12345678; PADDR_o stable throughout ACCESS.
REQ-037 Read with PSLVERR_i=1 and PREADY_i=1 -> rsp_error_o=1, rsp_timeout_o=0, rsp_rdata_o=0.
REQ-038 TIMEOUT_CYCLES=4, PREADY_i held 0 -> exactly 4 ACCESS cycles, then rsp_error_o=1, rsp_timeout_o=1; a second run with PREADY_i=1 on the 4th cycle -> no timeout.
REQ-039 rsp_ready_i held 0 for 5 cycles while cmd_valid_i=1 -> rsp_* stable, cmd_ready_o=0, no new PSEL_o.
REQ-040 PRESETn_i asserted during ACCESS -> PSEL_o/PENABLE_o=0 the same cycle, no rsp_valid_o after release, next command runs normally.
